// File: rtl/toy_mext_rs.sv
// toy_mext_rs: collapsing-queue reservation station in front of the M-extension unit.
// Entries stay packed toward slot 0, so slot 0 always holds the oldest micro-op.
// When an entry issues, every younger entry moves down one slot on the same edge.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   disp_vld/disp_rdy/disp_pld      dispatch handshake and opaque payload
//   disp_rs{1,2}_idx/_rdy           source tags and their already-ready bits
//   wake_en/wake_idx                wake-up broadcasts (port k at [k*PHY_W +: PHY_W])
//   cancel_en                       flush of the whole queue
//   issue_vld/issue_rdy/issue_*     issue handshake, payload and source tags
//   entry_cnt                       number of occupied entries
module toy_mext_rs #(
  parameter int DEPTH     = 4,
  parameter int PLD_WIDTH = 128,
  parameter int PHY_W     = 7,
  parameter int WAKE_NUM  = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        disp_vld,
  output logic                        disp_rdy,
  input  logic [PLD_WIDTH-1:0]        disp_pld,
  input  logic [PHY_W-1:0]            disp_rs1_idx,
  input  logic                        disp_rs1_rdy,
  input  logic [PHY_W-1:0]            disp_rs2_idx,
  input  logic                        disp_rs2_rdy,
  input  logic [WAKE_NUM-1:0]         wake_en,
  input  logic [WAKE_NUM*PHY_W-1:0]   wake_idx,
  input  logic                        cancel_en,
  output logic                        issue_vld,
  input  logic                        issue_rdy,
  output logic [PLD_WIDTH-1:0]        issue_pld,
  output logic [PHY_W-1:0]            issue_rs1_idx,
  output logic [PHY_W-1:0]            issue_rs2_idx,
  output logic [$clog2(DEPTH+1)-1:0]  entry_cnt
);

  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic                 vld;
    logic [PLD_WIDTH-1:0] pld;
    logic [PHY_W-1:0]     rs1_idx;
    logic                 rs1_rdy;
    logic [PHY_W-1:0]     rs2_idx;
    logic                 rs2_rdy;
  } ent_t;

  ent_t [DEPTH-1:0] ent_q, ent_w, ent_n;
  ent_t             new_ent;
  logic [CW-1:0]    cnt_q, cnt_n, wr_pos;
  logic             do_iss, do_disp;
  int               sel;

  // A tag matches if any enabled broadcast port carries that tag.
  function automatic logic woke(input logic [WAKE_NUM-1:0] en,
                                input logic [WAKE_NUM*PHY_W-1:0] idx,
                                input logic [PHY_W-1:0] tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WAKE_NUM; k++)
      if (en[k] && idx[k*PHY_W +: PHY_W] == tag) hit = 1'b1;
    return hit;
  endfunction

  assign disp_rdy  = (cnt_q < CW'(DEPTH));
  assign entry_cnt = cnt_q;

  // Apply this cycle's wakes to the stored entries. The woken state only feeds
  // the next-state logic. Select reads registered state, so wakes that arrive in
  // this cycle cannot make an entry issuable until the next cycle.
  always_comb begin
    ent_w         = ent_q;
    issue_vld     = 1'b0;
    issue_pld     = '0;
    issue_rs1_idx = '0;
    issue_rs2_idx = '0;
    sel           = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_w[i].rs1_rdy = ent_q[i].rs1_rdy | woke(wake_en, wake_idx, ent_q[i].rs1_idx);
      ent_w[i].rs2_rdy = ent_q[i].rs2_rdy | woke(wake_en, wake_idx, ent_q[i].rs2_idx);
    end
    // Scan from the youngest slot to the oldest, so the last hit is the oldest ready entry.
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (ent_q[i].vld && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
        issue_vld     = 1'b1;
        sel           = i;
        issue_pld     = ent_q[i].pld;
        issue_rs1_idx = ent_q[i].rs1_idx;
        issue_rs2_idx = ent_q[i].rs2_idx;
      end
    end
  end

  always_comb begin
    do_iss  = issue_vld & issue_rdy & ~cancel_en;
    do_disp = disp_vld & disp_rdy & ~cancel_en;

    new_ent.vld     = 1'b1;
    new_ent.pld     = disp_pld;
    new_ent.rs1_idx = disp_rs1_idx;
    new_ent.rs1_rdy = disp_rs1_rdy | woke(wake_en, wake_idx, disp_rs1_idx);
    new_ent.rs2_idx = disp_rs2_idx;
    new_ent.rs2_rdy = disp_rs2_rdy | woke(wake_en, wake_idx, disp_rs2_idx);

    // If an issue removes one entry in the same cycle, the new entry goes one slot lower.
    wr_pos = cnt_q - CW'(do_iss);
    ent_n  = ent_w;

    if (do_iss) begin
      for (int i = 0; i < DEPTH-1; i++)
        if (i >= sel) ent_n[i] = ent_w[i+1];
      ent_n[DEPTH-1] = '0;
    end

    for (int i = 0; i < DEPTH; i++)
      if (do_disp && wr_pos == CW'(i)) ent_n[i] = new_ent;

    cnt_n = cnt_q + CW'(do_disp) - CW'(do_iss);

    if (cancel_en) begin
      for (int i = 0; i < DEPTH; i++) ent_n[i].vld = 1'b0;
      cnt_n = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_n;
      cnt_q <= cnt_n;
    end
  end

endmodule

// File: tb/tb_toy_mext_rs.sv
// Bench for toy_mext_rs.
// A queue-based model is checked against the DUT on every falling edge.
// Literal checks are made after each directed step.
module tb_toy_mext_rs;
  localparam int DEPTH = 4, PLD_WIDTH = 128, PHY_W = 7, WAKE_NUM = 3;
  localparam int CW = $clog2(DEPTH+1);

  logic                       clk, rst_n;
  logic                       disp_vld, disp_rdy;
  logic [PLD_WIDTH-1:0]       disp_pld;
  logic [PHY_W-1:0]           disp_rs1_idx, disp_rs2_idx;
  logic                       disp_rs1_rdy, disp_rs2_rdy;
  logic [WAKE_NUM-1:0]        wake_en;
  logic [WAKE_NUM*PHY_W-1:0]  wake_idx;
  logic                       cancel_en;
  logic                       issue_vld, issue_rdy;
  logic [PLD_WIDTH-1:0]       issue_pld;
  logic [PHY_W-1:0]           issue_rs1_idx, issue_rs2_idx;
  logic [CW-1:0]              entry_cnt;

  toy_mext_rs #(.DEPTH(DEPTH), .PLD_WIDTH(PLD_WIDTH), .PHY_W(PHY_W), .WAKE_NUM(WAKE_NUM)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_vld(disp_vld), .disp_rdy(disp_rdy), .disp_pld(disp_pld),
    .disp_rs1_idx(disp_rs1_idx), .disp_rs1_rdy(disp_rs1_rdy),
    .disp_rs2_idx(disp_rs2_idx), .disp_rs2_rdy(disp_rs2_rdy),
    .wake_en(wake_en), .wake_idx(wake_idx), .cancel_en(cancel_en),
    .issue_vld(issue_vld), .issue_rdy(issue_rdy), .issue_pld(issue_pld),
    .issue_rs1_idx(issue_rs1_idx), .issue_rs2_idx(issue_rs2_idx),
    .entry_cnt(entry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [PLD_WIDTH-1:0] act, input logic [PLD_WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an age-ordered queue. The oldest ready entry issues. Wakes set ready bits.
  // New entries are appended at the tail.
  typedef struct {
    logic [PLD_WIDTH-1:0] pld;
    logic [PHY_W-1:0]     r1;
    logic                 r1r;
    logic [PHY_W-1:0]     r2;
    logic                 r2r;
  } m_t;
  m_t mq[$];
  m_t m_new;
  int m_sel;

  function automatic logic m_woke(input logic [PHY_W-1:0] tag);
    for (int k = 0; k < WAKE_NUM; k++)
      if (wake_en[k] && wake_idx[k*PHY_W +: PHY_W] == tag) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_oldest_ready();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].r1r && mq[i].r2r) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mq.delete();
    else if (cancel_en) mq.delete();
    else begin
      m_sel = m_oldest_ready();
      m_new.pld = disp_pld;
      m_new.r1  = disp_rs1_idx; m_new.r1r = disp_rs1_rdy | m_woke(disp_rs1_idx);
      m_new.r2  = disp_rs2_idx; m_new.r2r = disp_rs2_rdy | m_woke(disp_rs2_idx);
      for (int i = 0; i < mq.size(); i++) begin
        mq[i].r1r = mq[i].r1r | m_woke(mq[i].r1);
        mq[i].r2r = mq[i].r2r | m_woke(mq[i].r2);
      end
      if (disp_vld && mq.size() < DEPTH) begin
        if (m_sel >= 0 && issue_rdy) mq.delete(m_sel);
        mq.push_back(m_new);
      end else if (m_sel >= 0 && issue_rdy) mq.delete(m_sel);
    end
  end

  // Compare the DUT outputs with the model once per cycle.
  always @(negedge clk) begin
    int s;
    s = m_oldest_ready();
    chk("m_cnt", PLD_WIDTH'(entry_cnt), PLD_WIDTH'(mq.size()));
    chk("m_disp_rdy", PLD_WIDTH'(disp_rdy), PLD_WIDTH'(mq.size() < DEPTH));
    chk("m_issue_vld", PLD_WIDTH'(issue_vld), PLD_WIDTH'(s >= 0));
    if (s >= 0) begin
      chk("m_issue_pld", issue_pld, mq[s].pld);
      chk("m_issue_rs1", PLD_WIDTH'(issue_rs1_idx), PLD_WIDTH'(mq[s].r1));
      chk("m_issue_rs2", PLD_WIDTH'(issue_rs2_idx), PLD_WIDTH'(mq[s].r2));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    disp_vld = 1'b0; wake_en = '0; wake_idx = '0; cancel_en = 1'b0;
  endtask

  task automatic disp(input logic [PLD_WIDTH-1:0] p, input logic [PHY_W-1:0] a, input logic ar,
                      input logic [PHY_W-1:0] b, input logic br);
    disp_vld = 1'b1; disp_pld = p;
    disp_rs1_idx = a; disp_rs1_rdy = ar; disp_rs2_idx = b; disp_rs2_rdy = br;
  endtask

  task automatic wake(input int port, input logic [PHY_W-1:0] tag);
    wake_en[port] = 1'b1; wake_idx[port*PHY_W +: PHY_W] = tag;
  endtask

  logic [PLD_WIDTH-1:0] held;

  initial begin
    rst_n = 1'b0; issue_rdy = 1'b0;
    disp_pld = '0; disp_rs1_idx = '0; disp_rs2_idx = '0; disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0;
    idle();
    tick(); tick();
    chk("rst_vld", PLD_WIDTH'(issue_vld), 0);
    chk("rst_disp_rdy", PLD_WIDTH'(disp_rdy), 1);
    chk("rst_cnt", PLD_WIDTH'(entry_cnt), 0);
    chk("rst_pld", issue_pld, 0);
    rst_n = 1'b1;

    // 1: a dispatch with both sources ready issues on the next cycle.
    issue_rdy = 1'b1;
    disp(128'h11, 7'd1, 1'b1, 7'd2, 1'b1); tick(); idle();
    chk("t1_vld", PLD_WIDTH'(issue_vld), 1);
    chk("t1_pld", issue_pld, 128'h11);
    chk("t1_cnt1", PLD_WIDTH'(entry_cnt), 1);
    tick();
    chk("t1_cnt0", PLD_WIDTH'(entry_cnt), 0);

    // 2: a younger ready entry issues before an older one that is waiting.
    disp(128'h21, 7'd5, 1'b0, 7'd6, 1'b1); tick();
    chk("t2_a_wait", PLD_WIDTH'(issue_vld), 0);
    disp(128'h22, 7'd7, 1'b1, 7'd8, 1'b1); tick(); idle();
    chk("t2_b_first", issue_pld, 128'h22);
    wake(1, 7'd5); tick(); idle();
    chk("t2_a_vld", PLD_WIDTH'(issue_vld), 1);
    chk("t2_a_pld", issue_pld, 128'h21);
    chk("t2_a_rs1", PLD_WIDTH'(issue_rs1_idx), 5);
    tick();
    chk("t2_empty", PLD_WIDTH'(entry_cnt), 0);

    // 3: a wake in the dispatch cycle marks the new entry's source ready on entry.
    disp(128'h33, 7'd1, 1'b1, 7'd9, 1'b0); wake(0, 7'd9); tick(); idle();
    chk("t3_vld", PLD_WIDTH'(issue_vld), 1);
    chk("t3_pld", issue_pld, 128'h33);
    tick();

    // 4: fill the queue, hold the issue under back-pressure, then issue from the middle.
    issue_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      disp(PLD_WIDTH'(8'h40 + i), PHY_W'(10 + i), 1'b0, PHY_W'(20 + i), 1'b1); tick();
    end
    idle();
    chk("t4_full_cnt", PLD_WIDTH'(entry_cnt), 4);
    chk("t4_full_rdy", PLD_WIDTH'(disp_rdy), 0);
    wake(2, 7'd12); tick(); idle();
    chk("t4_vld", PLD_WIDTH'(issue_vld), 1);
    held = issue_pld;
    chk("t4_pld", held, 128'h42);
    disp(128'h4F, 7'd0, 1'b1, 7'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_stable", issue_pld, held);
    end
    idle();
    issue_rdy = 1'b1; tick();
    chk("t4_after_cnt", PLD_WIDTH'(entry_cnt), 3);
    chk("t4_after_rdy", PLD_WIDTH'(disp_rdy), 1);
    chk("t4_after_vld", PLD_WIDTH'(issue_vld), 0);
    issue_rdy = 1'b0;
    wake(0, 7'd13); tick(); idle();
    chk("t4_shifted", issue_pld, 128'h43);

    // 5: cancel with three entries held and a dispatch in the same cycle.
    issue_rdy = 1'b1;
    disp(128'h55, 7'd3, 1'b1, 7'd4, 1'b1); cancel_en = 1'b1; tick(); idle();
    chk("t5_cnt", PLD_WIDTH'(entry_cnt), 0);
    chk("t5_vld", PLD_WIDTH'(issue_vld), 0);
    tick();
    chk("t5_no_issue", PLD_WIDTH'(issue_vld), 0);

    // 6: reset in the middle of operation, then a fresh dispatch.
    issue_rdy = 1'b0;
    disp(128'h61, 7'd30, 1'b0, 7'd31, 1'b1); tick();
    disp(128'h62, 7'd32, 1'b1, 7'd33, 1'b1); tick(); idle();
    chk("t6_pre_vld", PLD_WIDTH'(issue_vld), 1);
    rst_n = 1'b0; #1;
    chk("t6_rst_vld", PLD_WIDTH'(issue_vld), 0);
    chk("t6_rst_rdy", PLD_WIDTH'(disp_rdy), 1);
    chk("t6_rst_cnt", PLD_WIDTH'(entry_cnt), 0);
    tick(); rst_n = 1'b1;
    issue_rdy = 1'b1;
    disp(128'h66, 7'd1, 1'b1, 7'd2, 1'b1); tick(); idle();
    chk("t6_fresh_vld", PLD_WIDTH'(issue_vld), 1);
    chk("t6_fresh_pld", issue_pld, 128'h66);
    tick();
    chk("t6_end_cnt", PLD_WIDTH'(entry_cnt), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
